// File: rtl/match_output_ctrl_if.sv
// Match-record input and result-stream output bundle of match_output_ctrl.
interface match_output_ctrl_if;
   logic        i_valid;
   logic        o_ready;
   logic [9:0]  i_src_coor_x;
   logic [9:0]  i_src_coor_y;
   logic [9:0]  i_src_depth;
   logic [9:0]  i_dst_coor_x;
   logic [9:0]  i_dst_coor_y;
   logic [9:0]  i_dst_depth;
   logic        i_frame_end;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [71:0] o_out_data;
   logic        o_out_last;

   modport slave (
      input  i_valid, i_src_coor_x, i_src_coor_y, i_src_depth,
      input  i_dst_coor_x, i_dst_coor_y, i_dst_depth, i_frame_end, i_out_ready,
      output o_ready, o_out_valid, o_out_data, o_out_last
   );

   modport master (
      output i_valid, i_src_coor_x, i_src_coor_y, i_src_depth,
      output i_dst_coor_x, i_dst_coor_y, i_dst_depth, i_frame_end, i_out_ready,
      input  o_ready, o_out_valid, o_out_data, o_out_last
   );
endinterface

// File: rtl/match_output_ctrl.sv
// Buffers a frame of match records, then emits count header + records (registered, 1 cycle after frame end);
// output holds under i_out_ready low, input stalls outside COLLECT. `MATCH_DEDUP_EN drops repeated records.
module match_output_ctrl #(
   parameter int MAX_MATCH = 199,
   parameter int CNT_W     = 8
) (
   input  logic                clk,
   input  logic                rst,
   match_output_ctrl_if.slave  bus,
   output logic                o_overflow,
   output logic                o_busy
);

   typedef enum logic [1:0] {S_COLLECT, S_HEADER, S_DRAIN} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_count, w_count_nxt;
   logic [CNT_W-1:0]  r_rd_ptr, w_rd_ptr_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic              r_out_valid, w_out_valid_nxt;
   logic              r_out_last, w_out_last_nxt;
   logic [71:0]       r_out_data, w_out_data_nxt;

   logic [59:0]       r_mem [MAX_MATCH];

   logic [59:0]       w_payload;
   logic              w_accept, w_full, w_dup, w_store;
   logic [CNT_W-1:0]  w_cnt_after, w_rd_inc;

   // Records are stored compacted; the 2-bit gaps are reinserted on the way out.
   function automatic logic [71:0] expand(input logic [59:0] p);
      return {2'b00, p[59:50], 2'b00, p[49:40], 2'b00, p[39:30],
              2'b00, p[29:20], 2'b00, p[19:10], 2'b00, p[9:0]};
   endfunction

   assign w_payload = {bus.i_src_coor_x, bus.i_src_coor_y, bus.i_src_depth,
                       bus.i_dst_coor_x, bus.i_dst_coor_y, bus.i_dst_depth};
   assign w_accept  = bus.i_valid && (r_state == S_COLLECT);
   assign w_full    = (r_count == CNT_W'(MAX_MATCH));

`ifdef MATCH_DEDUP_EN
   // r_count != 0 guards the first record of a frame from suppression.
   assign w_dup = (r_count != '0) && (w_payload == r_mem[r_count - CNT_W'(1)]);
`else
   assign w_dup = 1'b0;
`endif

   assign w_store     = w_accept && !w_full && !w_dup;
   assign w_cnt_after = w_store ? r_count + CNT_W'(1) : r_count;
   assign w_rd_inc    = r_rd_ptr + CNT_W'(1);

   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_rd_ptr_nxt    = r_rd_ptr;
      w_ovf_nxt       = r_ovf;
      w_out_valid_nxt = r_out_valid;
      w_out_last_nxt  = r_out_last;
      w_out_data_nxt  = r_out_data;
      case (r_state)
         S_COLLECT: begin
            w_count_nxt = w_cnt_after;
            if (w_accept && w_full && !w_dup)
               w_ovf_nxt = 1'b1;
            if (bus.i_frame_end) begin
               w_state_nxt     = S_HEADER;
               w_out_valid_nxt = 1'b1;
               w_out_data_nxt  = {{(72-CNT_W){1'b0}}, w_cnt_after};
               w_out_last_nxt  = (w_cnt_after == '0);
            end
         end
         S_HEADER: begin
            if (bus.i_out_ready) begin
               if (r_count != '0) begin
                  w_state_nxt    = S_DRAIN;
                  w_rd_ptr_nxt   = '0;
                  w_out_data_nxt = expand(r_mem[0]);
                  w_out_last_nxt = (r_count == CNT_W'(1));
               end else begin
                  w_state_nxt     = S_COLLECT;
                  w_out_valid_nxt = 1'b0;
                  w_out_last_nxt  = 1'b0;
                  w_ovf_nxt       = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            if (bus.i_out_ready) begin
               if (r_out_last) begin
                  w_state_nxt     = S_COLLECT;
                  w_out_valid_nxt = 1'b0;
                  w_out_last_nxt  = 1'b0;
                  w_count_nxt     = '0;
                  w_rd_ptr_nxt    = '0;
                  w_ovf_nxt       = 1'b0;
               end else begin
                  w_rd_ptr_nxt   = w_rd_inc;
                  w_out_data_nxt = expand(r_mem[w_rd_inc]);
                  w_out_last_nxt = (w_rd_inc == r_count - CNT_W'(1));
               end
            end
         end
         default: w_state_nxt = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_COLLECT;
         r_count     <= '0;
         r_rd_ptr    <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_ovf       <= w_ovf_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_last  <= w_out_last_nxt;
         r_out_data  <= w_out_data_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_store)
         r_mem[r_count] <= w_payload;
   end

   assign bus.o_ready     = (r_state == S_COLLECT);
   assign bus.o_out_valid = r_out_valid;
   assign bus.o_out_data  = r_out_data;
   assign bus.o_out_last  = r_out_last;
   assign o_overflow      = r_ovf;
   assign o_busy          = (r_state != S_COLLECT);

endmodule
